// File: rtl/seg7_mux_capture_if.sv
// Multiplexed seven-segment display bus: active-low segment lines and anode selects.
interface seg7_mux_capture_if;
    logic [7:0] seg_in;
    logic [3:0] an_in;

    modport master (output seg_in, output an_in);
    modport slave  (input  seg_in, input  an_in);
endinterface

// File: rtl/seg7_mux_capture.sv
// Display loopback monitor: rebuilds 4-digit frames from a muxed 7-seg bus and measures scroll period.
// Optional SEG7_DP_MASK_EN: ignore the decimal point in stability, capture and frame comparison.
//
// state    | meaning
// ST_LOST  | no anode activity seen recently; disp_lost high, frame history discarded
// ST_TRACK | display alive; frames being assembled and compared
module seg7_mux_capture #(
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int PER_W       = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    seg7_mux_capture_if.slave bus,
    output logic [31:0]       frame,
    output logic              frame_valid,
    output logic              frame_changed,
    output logic [PER_W-1:0]  scroll_period,
    output logic              mux_err,
    output logic              disp_lost
);
    localparam logic [0:0] ST_LOST  = 1'b0;
    localparam logic [0:0] ST_TRACK = 1'b1;

    localparam int CNT_W  = $clog2(SETTLE_CYC + 1);
    localparam int IDLE_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0]  SET_MAX = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0]  SET_M1  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [IDLE_W-1:0] IDLE_M1 = IDLE_W'(TIMEOUT_CYC - 1);

    logic [0:0]        state;
    logic [7:0]        seg_s1, seg_s2, seg_cur, seg_prev;
    logic [3:0]        an_s1, an_s2, an_prev, an_act;
    logic [CNT_W-1:0]  stab_cnt, cnt_nxt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [PER_W-1:0]  per_cnt, per_inc;
    logic [31:0]       shadow, shadow_nxt;
    logic [3:0]        seen, seen_nxt;
    logic [1:0]        idx;
    logic              valid, blank, illegal, changed, capture, complete;
    logic              frame_diff, timeout, enter_lost, lost_pend, have_frame;

`ifdef SEG7_DP_MASK_EN
    assign seg_cur = {1'b0, ~seg_s2[6:0]};
`else
    assign seg_cur = ~seg_s2;
`endif

    assign an_act  = ~an_s2;
    assign valid   = $onehot(an_act);
    assign blank   = (an_act == 4'd0);
    assign illegal = !valid && !blank;
    assign changed = (seg_cur != seg_prev) || (an_s2 != an_prev);

    always_comb begin
        idx = 2'd0;
        for (int i = 0; i < 4; i++)
            if (an_act[i]) idx = 2'(i);
    end

    always_comb begin
        cnt_nxt = stab_cnt;
        if (changed || blank)
            cnt_nxt = '0;
        else if (stab_cnt != SET_MAX)
            cnt_nxt = stab_cnt + 1'b1;
    end

    // Fires once per stable run; the change term covers SETTLE_CYC == 1.
    assign capture = valid && (cnt_nxt == SET_M1) && (changed || stab_cnt != SET_M1);

    always_comb begin
        shadow_nxt = shadow;
        seen_nxt   = seen;
        if (capture) begin
            shadow_nxt[{idx, 3'b000} +: 8] = seg_cur;
            seen_nxt[idx]                  = 1'b1;
        end
    end

    assign complete   = (seen_nxt == 4'b1111);
    assign frame_diff = complete && have_frame && (shadow_nxt != frame);
    assign per_inc    = (per_cnt == '1) ? per_cnt : per_cnt + 1'b1;
    assign timeout    = (state == ST_TRACK) && (idle_cnt == IDLE_M1);
    // A completion on the timeout clock wins; the loss is taken one clock later.
    assign enter_lost = (state == ST_TRACK) && ((timeout && !complete) || lost_pend);
    assign disp_lost  = (state == ST_LOST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1        <= 8'hFF;
            seg_s2        <= 8'hFF;
            an_s1         <= 4'hF;
            an_s2         <= 4'hF;
            seg_prev      <= 8'h00;
            an_prev       <= 4'hF;
            stab_cnt      <= '0;
            idle_cnt      <= '0;
            per_cnt       <= '0;
            shadow        <= '0;
            seen          <= '0;
            have_frame    <= 1'b0;
            lost_pend     <= 1'b0;
            state         <= ST_LOST;
            frame         <= '0;
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
            scroll_period <= '0;
            mux_err       <= 1'b0;
        end else begin
            seg_s1   <= bus.seg_in;
            seg_s2   <= seg_s1;
            an_s1    <= bus.an_in;
            an_s2    <= an_s1;
            seg_prev <= seg_cur;
            an_prev  <= an_s2;
            stab_cnt <= cnt_nxt;
            shadow   <= shadow_nxt;
            mux_err  <= illegal && (cnt_nxt == SET_MAX) && (stab_cnt != SET_MAX);

            if (valid)
                idle_cnt <= '0;
            else if (idle_cnt != IDLE_M1)
                idle_cnt <= idle_cnt + 1'b1;

            frame_valid   <= complete;
            frame_changed <= frame_diff;
            lost_pend     <= timeout && complete;
            if (complete)
                frame <= shadow_nxt;
            if (frame_diff)
                scroll_period <= per_inc;

            if (enter_lost) begin
                seen       <= '0;
                have_frame <= 1'b0;
                per_cnt    <= '0;
            end else begin
                seen <= complete ? 4'b0000 : seen_nxt;
                if (complete)
                    have_frame <= 1'b1;
                if (frame_diff)
                    per_cnt <= '0;
                else if (have_frame)
                    per_cnt <= per_inc;
            end

            if (enter_lost)
                state <= ST_LOST;
            else if (state == ST_LOST && capture)
                state <= ST_TRACK;
        end
    end
endmodule

// File: tb/tb_seg7_mux_capture.sv
// Directed bench for seg7_mux_capture: frame rebuild, scroll period, glitch/mux error, timeout, dp, reset.
module tb_seg7_mux_capture;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] frame;
    logic        frame_valid, frame_changed, mux_err, disp_lost;
    logic [23:0] scroll_period;

    int checks = 0;
    int failures = 0;
    int nv = 0, nc = 0, nm = 0;
    int nv0, nc0, nm0;

    localparam logic [31:0] F0 = 32'h7679383F;
    localparam logic [31:0] F1 = 32'h79383F00;
    localparam logic [31:0] F2 = 32'h383F0076;
    localparam logic [31:0] F3 = 32'h3F007679;

    always #10 clk = ~clk;

    seg7_mux_capture_if bus ();

    seg7_mux_capture #(.SETTLE_CYC(4), .TIMEOUT_CYC(1000), .PER_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .frame(frame), .frame_valid(frame_valid), .frame_changed(frame_changed),
        .scroll_period(scroll_period), .mux_err(mux_err), .disp_lost(disp_lost)
    );

    always @(negedge clk) begin
        if (frame_valid)   nv++;
        if (frame_changed) nc++;
        if (mux_err)       nm++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        nv0 = nv; nc0 = nc; nm0 = nm;
    endtask

    task automatic show_digit(input int d, input logic [7:0] s, input int n);
        bus.an_in  = ~(4'b0001 << d);
        bus.seg_in = ~s;
        cyc(n);
    endtask

    task automatic show_frame(input logic [31:0] f);
        for (int d = 3; d >= 0; d--) show_digit(d, f[d*8 +: 8], 100);
    endtask

    task automatic go_idle(input int n);
        bus.an_in  = 4'hF;
        bus.seg_in = 8'hFF;
        cyc(n);
    endtask

    initial begin
        logic [31:0] fdp, fdp_exp;
        int          dp_changes;
        bus.an_in  = 4'hF;
        bus.seg_in = 8'hFF;
        cyc(3);
        rst_n = 1'b1;

        // Idle bus after reset
        mark();
        go_idle(50);
        chk("rst_frame", frame, 32'h0);
        chk("rst_period", {8'h0, scroll_period}, 32'h0);
        chk("rst_lost", {31'h0, disp_lost}, 32'h1);
        chk("rst_pulses", nv + nc + nm, 32'h0);

        // First frame "HELO"
        mark();
        show_frame(F0);
        chk("first_valid_cnt", nv - nv0, 32'd1);
        chk("first_frame", frame, F0);
        chk("first_changed_cnt", nc - nc0, 32'd0);
        chk("first_lost", {31'h0, disp_lost}, 32'h0);

        // Repeats, then scroll one char every 5 refresh frames
        mark();
        for (int i = 0; i < 3; i++) show_frame(F0);
        chk("repeat_changed_cnt", nc - nc0, 32'd0);
        chk("repeat_valid_cnt", nv - nv0, 32'd3);
        for (int i = 0; i < 5; i++) show_frame(F1);
        chk("shift1_period", {8'h0, scroll_period}, 32'd1600);
        chk("shift1_frame", frame, F1);
        for (int i = 0; i < 5; i++) show_frame(F2);
        chk("shift2_period", {8'h0, scroll_period}, 32'd2000);
        mark();
        for (int i = 0; i < 5; i++) show_frame(F3);
        chk("shift3_changed_cnt", nc - nc0, 32'd1);
        chk("shift3_period", {8'h0, scroll_period}, 32'd2000);
        chk("shift3_frame", frame, F3);

        // Glitchy digit 0 and illegal anode pattern: no capture
        mark();
        for (int d = 3; d >= 1; d--) show_digit(d, F3[d*8 +: 8], 100);
        for (int i = 0; i < 5; i++) begin
            show_digit(0, 8'h06, 3);
            show_digit(0, 8'h5B, 3);
        end
        go_idle(20);
        chk("glitch_no_capture", nv - nv0, 32'd0);
        bus.an_in  = 4'b1100;
        bus.seg_in = 8'h00;
        cyc(10);
        go_idle(10);
        chk("mux_err_cnt", nm - nm0, 32'd1);
        chk("illegal_no_capture", nv - nv0, 32'd0);
        show_digit(0, F3[7:0], 100);
        chk("glitch_done_valid", nv - nv0, 32'd1);
        chk("glitch_done_frame", frame, F3);
        chk("glitch_done_changed", nc - nc0, 32'd0);

        // Display loss after 1000 idle clocks (plus 2 sync clocks)
        bus.an_in  = 4'hF;
        bus.seg_in = 8'hFF;
        cyc(995);
        chk("timeout_early", {31'h0, disp_lost}, 32'h0);
        cyc(10);
        chk("timeout_lost", {31'h0, disp_lost}, 32'h1);
        chk("timeout_frame_kept", frame, F3);
        chk("timeout_period_kept", {8'h0, scroll_period}, 32'd2000);

        // Resume: first frame after loss is not a change
        mark();
        show_frame(F0);
        chk("resume_lost", {31'h0, disp_lost}, 32'h0);
        chk("resume_valid", nv - nv0, 32'd1);
        chk("resume_changed", nc - nc0, 32'd0);
        chk("resume_frame", frame, F0);

        // Decimal point on digit 0 only
        mark();
        fdp = F0 | 32'h0000_0080;
`ifdef SEG7_DP_MASK_EN
        fdp_exp    = F0;
        dp_changes = 0;
`else
        fdp_exp    = fdp;
        dp_changes = 1;
`endif
        show_frame(fdp);
        chk("dp_frame", frame, fdp_exp);
        chk("dp_changed_cnt", nc - nc0, dp_changes);

        // Asynchronous reset mid-frame
        show_digit(3, F1[31:24], 100);
        show_digit(2, F1[23:16], 50);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_frame", frame, 32'h0);
        chk("arst_period", {8'h0, scroll_period}, 32'h0);
        chk("arst_pulses", {29'h0, frame_valid, frame_changed, mux_err}, 32'h0);
        chk("arst_lost", {31'h0, disp_lost}, 32'h1);
        go_idle(2);
        rst_n = 1'b1;
        go_idle(5);
        mark();
        show_digit(1, F1[15:8], 100);
        show_digit(0, F1[7:0], 100);
        go_idle(50);
        chk("arst_partial_discarded", nv - nv0, 32'd0);
        show_frame(F1);
        chk("arst_full_valid", nv - nv0, 32'd1);
        chk("arst_full_frame", frame, F1);
        chk("arst_full_changed", nc - nc0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
